// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Grants bounded bursts, registers write data and throttles on FIFO full flags.
module fifo_write_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ack,
  output logic [NREQ-1:0]        grant,
  input  logic                   fifo_almost_full,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DWIDTH-1:0]      fifo_din,
  output logic                   busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_BURST);
  localparam logic [IW-1:0] LastRst = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StBurst = 3'b010,
    StStall = 3'b100
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [IW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [DWIDTH-1:0]   din_q, din_d;
  logic                busy_q, busy_d;

  logic                block;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [DWIDTH-1:0]   data_arr [NREQ];
  logic [DWIDTH-1:0]   g_data;
  logic                g_valid;
  logic [CW-1:0]       cnt_inc;

  // Second term: a write already registered will consume the last free slot.
  assign block   = fifo_full | (fifo_almost_full & wr_q);
  assign g_data  = data_arr[last_q];
  assign g_valid = req_valid[last_q];
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      data_arr[i] = req_data[i*DWIDTH +: DWIDTH];
    end
  end

  // Search starts just after the most recent grant and wraps.
  always_comb begin
    int unsigned  cand;
    logic [IW-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(last_q) + k) % NREQ;
      cand_idx = cand[IW-1:0];
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    din_d   = din_q;
    req_ack = '0;

    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (pick_found && !block) begin
          grant_d = NREQ'(1) << pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (g_valid && !block) begin
          req_ack = NREQ'(1) << last_q;
          wr_d    = 1'b1;
          din_d   = g_data;
          cnt_d   = cnt_inc;
          if (cnt_inc == MaxCnt) begin
            state_d = StIdle;
            grant_d = '0;
          end
        end else if (!g_valid) begin
          state_d = StIdle;
          grant_d = '0;
        end else begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (!block) begin
          if (g_valid) begin
            state_d = StBurst;
          end else begin
            state_d = StIdle;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase

    // The acknowledge is combinational, so it must be masked while in reset.
    if (reset) begin
      req_ack = '0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= LastRst;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign fifo_wr_en = wr_q;
  assign fifo_din   = din_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: queue-driven requesters, a behavioural model
// checked every cycle, and literal expectations per directed scenario.
module tb_fifo_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MB   = 4;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ack;
  logic [NREQ-1:0]      grant;
  logic                 fifo_almost_full;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [DW-1:0]        fifo_din;
  logic                 busy;

  fifo_write_arbiter #(
    .NREQ      (NREQ),
    .DWIDTH    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ack          (req_ack),
    .grant            (grant),
    .fifo_almost_full (fifo_almost_full),
    .fifo_full        (fifo_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_din         (fifo_din),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int miscmp = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Requester word queues.
  logic [DW-1:0] words [NREQ][16];
  int head [NREQ];
  int tail [NREQ];

  // Behavioural model: owner -1 means nobody holds the port.
  int            m_owner;
  int            m_beats;
  int            m_last;
  bit            m_stall;
  bit            m_wr;
  logic [DW-1:0] m_din;

  logic [NREQ-1:0] exp_ack, exp_grant;
  logic            exp_wr, exp_busy;
  logic [DW-1:0]   exp_din;

  logic [NREQ-1:0] ack_log [64];
  logic [NREQ-1:0] grant_log [64];
  logic            wr_log [64];
  logic            full_log [64];
  logic            busy_log [64];
  logic [DW-1:0]   din_log [64];
  logic [DW-1:0]   got [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_block();
    return fifo_full || (fifo_almost_full && m_wr);
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (head[i] < tail[i]);
      req_data[i*DW +: DW] = (head[i] < tail[i]) ? words[i][head[i]] : '0;
    end
  endtask

  task automatic model_eval();
    exp_grant = '0;
    exp_ack   = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    exp_busy = (m_owner >= 0);
    exp_wr   = m_wr;
    exp_din  = m_din;
    if (!reset && m_owner >= 0 && !m_stall && req_valid[m_owner] && !m_block())
      exp_ack[m_owner] = 1'b1;
  endtask

  task automatic model_step();
    bit blk, nwr, found;
    blk = m_block();
    nwr = 0;
    if (reset) begin
      m_owner = -1; m_stall = 0; m_beats = 0; m_last = NREQ - 1; m_din = '0;
    end else if (m_owner < 0) begin
      found = 0;
      if (!blk) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (!found && req_valid[c]) begin
            found = 1; m_owner = c; m_last = c; m_beats = 0; m_stall = 0;
          end
        end
      end
    end else if (!m_stall) begin
      if (req_valid[m_owner] && !blk) begin
        nwr = 1;
        m_din = words[m_owner][head[m_owner]];
        head[m_owner]++;
        m_beats++;
        if (m_beats == MB) m_owner = -1;
      end else if (!req_valid[m_owner]) begin
        m_owner = -1;
      end else begin
        m_stall = 1;
      end
    end else if (!blk) begin
      m_stall = 0;
      if (!req_valid[m_owner]) m_owner = -1;
    end
    m_wr = nwr;
  endtask

  task automatic tick(input bit af, input bit full, input bit rst);
    fifo_almost_full = af;
    fifo_full        = full;
    reset            = rst;
    drive_reqs();
    model_eval();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic run_n(input int n);
    repeat (n) tick(0, 0, 0);
  endtask

  task automatic push_word(input int r, input logic [DW-1:0] w);
    words[r][tail[r]] = w;
    tail[r]++;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    tick(0, 0, 1);
    chk_en = 1;
    tick(0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      ack_log[i] = '0; grant_log[i] = '0; wr_log[i] = 0;
      full_log[i] = 0; busy_log[i] = 0; din_log[i] = '0;
    end
    got.delete();
    cyc = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ack", 64'(req_ack), 64'(exp_ack));
      check("grant", 64'(grant), 64'(exp_grant));
      check("fifo_wr_en", 64'(fifo_wr_en), 64'(exp_wr));
      check("fifo_din", 64'(fifo_din), 64'(exp_din));
      check("busy", 64'(busy), 64'(exp_busy));
      if (cyc < 64) begin
        ack_log[cyc]   = req_ack;
        grant_log[cyc] = grant;
        wr_log[cyc]    = fifo_wr_en;
        full_log[cyc]  = fifo_full;
        busy_log[cyc]  = busy;
        din_log[cyc]   = fifo_din;
      end
      if (fifo_wr_en === 1'b1) got.push_back(fifo_din);
    end
  end

  initial begin
    int p1 [9]  = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
    int p3 [8]  = '{0, 1, 0, 0, 1, 1, 1, 0};
    int p4 [13] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    int g5 [7]  = '{0, 2, 2, 2, 0, 8, 8};
    int a5 [8]  = '{0, 2, 2, 0, 0, 8, 8, 8};
    int rv_exp [5] = '{1, 2, 4, 8, 1};
    int rv [$];
    int rl [$];
    int bad;

    reset = 1; req_valid = '0; req_data = '0;
    fifo_almost_full = 0; fifo_full = 0;
    m_owner = -1; m_stall = 0; m_beats = 0; m_last = NREQ - 1; m_wr = 0; m_din = '0;
    @(posedge clk);
    #1;

    // Requester 0 alone streams six words.
    reset_dut();
    for (int k = 0; k < 6; k++) push_word(0, 32'hA0 + k);
    run_n(12);
    check("t1_reset_grant", 64'(grant_log[0]), 0);
    check("t1_reset_busy", 64'(busy_log[0]), 0);
    check("t1_reset_wr", 64'(wr_log[0]), 0);
    check("t1_reset_din", 64'(din_log[0]), 0);
    for (int c = 0; c < 9; c++) check("t1_ack0", 64'(ack_log[c][0]), 64'(p1[c]));
    check("t1_gap_grant", 64'(grant_log[5]), 0);
    check("t1_nwords", 64'(got.size()), 6);
    for (int k = 0; k < 6; k++) check("t1_order", 64'(got[k]), 64'(32'hA0 + k));

    // All requesters continuously valid.
    reset_dut();
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < 8; k++) push_word(r, 32'(r * 16 + k));
    run_n(44);
    for (int c = 0; c < 44; c++) begin
      if (grant_log[c] != 0) begin
        if (c == 0 || grant_log[c-1] != grant_log[c]) begin
          rv.push_back(int'(grant_log[c]));
          rl.push_back(1);
        end else begin
          rl[rl.size()-1]++;
        end
      end
    end
    check("t2_nruns", 64'(rv.size()), 8);
    for (int i = 0; i < 5; i++) begin
      check("t2_grant_seq", 64'(rv[i]), 64'(rv_exp[i]));
      check("t2_run_len", 64'(rl[i]), 4);
    end
    check("t2_nwords", 64'(got.size()), 32);

    // almost_full rises in the cycle after an accept.
    reset_dut();
    for (int k = 0; k < 4; k++) push_word(0, 32'hB0 + k);
    tick(0, 0, 0); tick(0, 0, 0); tick(1, 0, 0);
    run_n(7);
    for (int c = 0; c < 8; c++) check("t3_ack0", 64'(ack_log[c][0]), 64'(p3[c]));
    check("t3_stall_grant", 64'(grant_log[3]), 1);
    check("t3_stall_busy", 64'(busy_log[3]), 1);
    check("t3_nwords", 64'(got.size()), 4);
    for (int k = 0; k < 4; k++) check("t3_order", 64'(got[k]), 64'(32'hB0 + k));

    // fifo_full held five cycles mid-burst of requester 2.
    reset_dut();
    for (int k = 0; k < 6; k++) push_word(2, 32'hC0 + k);
    tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0); tick(1, 0, 0);
    repeat (5) tick(1, 1, 0);
    run_n(9);
    for (int c = 0; c < 13; c++) check("t4_ack2", 64'(ack_log[c][2]), 64'(p4[c]));
    check("t4_burst_end", 64'(grant_log[12]), 0);
    bad = 0;
    for (int c = 0; c < 18; c++) if (wr_log[c] && full_log[c]) bad++;
    check("t4_wr_while_full", 64'(bad), 0);
    check("t4_nwords", 64'(got.size()), 6);
    for (int k = 0; k < 6; k++) check("t4_order", 64'(got[k]), 64'(32'hC0 + k));

    // Requester 1 drops after two acks, requester 3 waiting.
    reset_dut();
    push_word(1, 32'hD0); push_word(1, 32'hD1);
    for (int k = 0; k < 3; k++) push_word(3, 32'hE0 + k);
    run_n(10);
    for (int c = 0; c < 7; c++) check("t5_grant", 64'(grant_log[c]), 64'(g5[c]));
    for (int c = 0; c < 8; c++) check("t5_ack", 64'(ack_log[c]), 64'(a5[c]));
    check("t5_nwords", 64'(got.size()), 5);

    // Reset pulsed mid-burst.
    reset_dut();
    for (int k = 0; k < 4; k++) push_word(0, 32'hF0 + k);
    for (int k = 0; k < 4; k++) push_word(2, 32'h90 + k);
    tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 1);
    run_n(6);
    check("t6_ack_in_reset", 64'(ack_log[3]), 0);
    check("t6_wr_before", 64'(wr_log[3]), 1);
    check("t6_rst_grant", 64'(grant_log[4]), 0);
    check("t6_rst_wr", 64'(wr_log[4]), 0);
    check("t6_rst_busy", 64'(busy_log[4]), 0);
    check("t6_rst_din", 64'(din_log[4]), 0);
    check("t6_regrant", 64'(grant_log[5]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares one FIFO write port between NREQ actor output ports. It grants one requester at a time for a bounded burst and registers the write data toward the FIFO. It throttles on the FIFO's `fifo_almost_full`/`fifo_full` flags so that no write is ever issued into a full FIFO. It sits between multiple producer actors and a single inter-actor FIFO, upstream of the FIFO's write side.

## Interface
- NREQ, 4: number of requesters, 2..16.
- DWIDTH, 32: data width per requester and FIFO word width.
- MAX_BURST, 4: maximum words accepted per grant, at least 1.

- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i high when requester i has a word on its data slice.
- req_data  input  NREQ*DWIDTH  requester i data in bits [i*DWIDTH +: DWIDTH].
- req_ack  output  NREQ  combinational; bit i high in a cycle where requester i's word is accepted.
- grant  output  NREQ  registered one-hot owner of the write port; all zeros when idle.
- fifo_almost_full  input  1  FIFO has exactly one free slot, or none.
- fifo_full  input  1  FIFO has no free slot.
- fifo_wr_en  output  1  registered FIFO write strobe.
- fifo_din  output  DWIDTH  registered FIFO write data.
- busy  output  1  registered; high whenever the state is not IDLE.

## Operation
- States, one-hot encoded: IDLE, BURST, STALL. Any illegal encoding returns to IDLE on the next edge with grant cleared.
- Round-robin pointer `last` holds the index of the most recent grant. On reset it is NREQ-1, so requester 0 has first priority.
- block = fifo_full OR (fifo_almost_full AND fifo_wr_en). The second term covers the one write already in flight.
- IDLE:
  - If any req_valid bit is high and block is 0, select the first requester with req_valid set, searching from last+1 upward and wrapping modulo NREQ.
  - On selection: grant ← one-hot of that index, last ← that index, beat count ← 0, go to BURST.
  - Otherwise stay in IDLE with grant at 0.
- BURST, with g the granted index:
  - accept = req_valid[g] AND NOT block.
  - req_ack[g] = accept; every other req_ack bit is 0.
  - On accept: fifo_din ← req_data slice g, fifo_wr_en ← 1 on the next edge, beat count increments.
  - Exit to IDLE, clearing grant, when the accept makes the count reach MAX_BURST, or when req_valid[g] is 0.
  - If req_valid[g] is 1 and block is 1, go to STALL. Grant and count are kept.
- STALL:
  - No accept; req_ack is 0.
  - When block is 0, return to BURST. If req_valid[g] has dropped by then, go to IDLE instead.
- fifo_wr_en is 0 in every cycle that does not follow an accept. fifo_din holds its last value when fifo_wr_en is 0.
- Beat counter width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- Words from a single requester reach the FIFO in acceptance order. No word is dropped or duplicated.

## Timing
- Reset values: state IDLE, grant 0, fifo_wr_en 0, fifo_din 0, busy 0, last NREQ-1, count 0. req_ack is 0 throughout reset.
- Grant latency: 1 cycle from req_valid (seen in IDLE) to grant. The first accept can happen in the cycle grant is visible.
- Data latency: 1 cycle from accept (req_ack high) to fifo_wr_en/fifo_din.
- Requester rule: hold req_valid and data until req_ack. A requester may drop req_valid only after an ack.
- Every burst ends with one idle arbitration cycle, so peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Simultaneous requests: the round-robin search decides; no requester wins twice in a row while another one is waiting.
- fifo_full and fifo_almost_full high together count as block; fifo_almost_full alone with no write in flight still allows one accept.
- Reset asserted mid-burst: the next edge gives reset values. Any write already registered is cancelled, meaning fifo_wr_en is 0 after that edge.

## Test plan
- NREQ=4, MAX_BURST=4, requester 0 alone streams 6 words (0xA0..0xA5) -> acks in cycles 1-4 after grant, then one cycle with grant=0, re-grant to requester 0, remaining 2 words; FIFO receives 0xA0..0xA5 in order.
- All 4 requesters continuously valid -> grant sequence 0001, 0010, 0100, 1000, 0001; each grant accepts exactly 4 words.
- fifo_almost_full rises in the cycle after an accept -> no accept that cycle, state goes to STALL. After almost_full clears, accepts resume with the same grant; total writes are unchanged.
- fifo_full held for 5 cycles mid-burst of requester 2 -> fifo_wr_en never high while full, req_ack 0 for 5 cycles, burst count preserved on resume.
- Requester 1 drops req_valid after 2 acks while requester 3 is waiting -> 2 writes, IDLE, grant moves to requester 3 on the next edge.
- reset pulsed in the middle of a burst -> outputs at reset values next cycle; after release, with 0 and 2 requesting, requester 0 is granted first.
